imuldiv_mul_arbiter: RTL and testbench

IMULDIV_MUL_ARBITER -- requirements
Module: imuldiv_mul_arbiter

---
 rtl/imuldiv_mul_arbiter.sv | 174 +++++++++++++++++
 tb/tb_imuldiv_mul_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_mul_arbiter.sv
// imuldiv_mul_arbiter
// Shares one iterative multiplier between two requesters. A small IDLE/BUSY/RESP
// FSM allows at most one operation in flight. In IDLE a round-robin grant picks a
// requester and passes its handshake straight through to the multiplier. The
// multiplier result is buffered, and the buffer is then presented to the owning
// requester. Per-port counters record completed operations.
//
// Handshake semantics (all val/rdy pairs): a transfer happens on a rising clk
// edge where both val and rdy are 1. A producer holds val and its message stable
// until that transfer. A consumer may raise or drop rdy at any time. rdy never
// depends on a transfer in the same cycle, only on the current state and on
// inputs.

module imuldiv_mul_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  // requester 0
  input  logic [31:0]      req0_msg_a,
  input  logic [31:0]      req0_msg_b,
  input  logic             req0_val,
  output logic             req0_rdy,

  // requester 1
  input  logic [31:0]      req1_msg_a,
  input  logic [31:0]      req1_msg_b,
  input  logic             req1_val,
  output logic             req1_rdy,

  // responses back to the requesters
  output logic [63:0]      resp0_msg,
  output logic             resp0_val,
  input  logic             resp0_rdy,
  output logic [63:0]      resp1_msg,
  output logic             resp1_val,
  input  logic             resp1_rdy,

  // shared multiplier
  output logic [31:0]      mul_req_msg_a,
  output logic [31:0]      mul_req_msg_b,
  output logic             mul_req_val,
  input  logic             mul_req_rdy,
  input  logic [63:0]      mul_resp_msg,
  input  logic             mul_resp_val,
  output logic             mul_resp_rdy,

  // completed-operation counters
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,

  // FSM state, exposed for observation
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        pri;        // port that wins when both request together
  logic        owner;      // port that owns the in-flight operation
  logic [63:0] resp_buf;   // multiplier result awaiting the owner

  logic        gnt_val;
  logic        gnt_sel;
  logic        mul_req_xfer;
  logic        mul_resp_xfer;
  logic        resp_xfer;

  assign state_dbg = state;

  // Grant selection: only in IDLE and outside reset; round-robin on contention
  always_comb begin
    gnt_val = 1'b0;
    gnt_sel = 1'b0;
    if ((state == IDLE) && !reset) begin
      if (req0_val && req1_val) begin
        gnt_val = 1'b1;
        gnt_sel = pri;
      end else if (req0_val) begin
        gnt_val = 1'b1;
        gnt_sel = 1'b0;
      end else if (req1_val) begin
        gnt_val = 1'b1;
        gnt_sel = 1'b1;
      end
    end
  end

  // The granted requester talks to the multiplier directly; operands are zero with no grant
  always_comb begin
    mul_req_val   = gnt_val;
    mul_req_msg_a = 32'd0;
    mul_req_msg_b = 32'd0;
    if (gnt_val) begin
      mul_req_msg_a = gnt_sel ? req1_msg_a : req0_msg_a;
      mul_req_msg_b = gnt_sel ? req1_msg_b : req0_msg_b;
    end
  end

  assign req0_rdy = gnt_val && !gnt_sel && mul_req_rdy;
  assign req1_rdy = gnt_val &&  gnt_sel && mul_req_rdy;

  // Result capture is only open while an operation is in the multiplier
  assign mul_resp_rdy = (state == BUSY);

  // Buffered result goes to the owner only; both message buses carry the buffer
  assign resp0_val = (state == RESP) && !owner;
  assign resp1_val = (state == RESP) &&  owner;
  assign resp0_msg = resp_buf;
  assign resp1_msg = resp_buf;

  assign mul_req_xfer  = mul_req_val && mul_req_rdy;
  assign mul_resp_xfer = mul_resp_val && mul_resp_rdy;
  assign resp_xfer     = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);

  // Next-state logic; RESP always returns to IDLE before the next grant
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_req_xfer)  state_nxt = BUSY;
      BUSY:    if (mul_resp_xfer) state_nxt = RESP;
      RESP:    if (resp_xfer)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ownership and round-robin pointer move only on a multiplier request transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 1'b0;
      pri   <= 1'b0;
    end else if (mul_req_xfer) begin
      owner <= gnt_sel;
      pri   <= !gnt_sel;
    end
  end

  // Hold the multiplier result until the owner accepts it
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_buf <= 64'd0;
    end else if (mul_resp_xfer) begin
      resp_buf <= mul_resp_msg;
    end
  end

  // Count completions per port; counters wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (resp_xfer) begin
      if (owner) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end else begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter. A behavioural multiplier answers the shared
// multiplier port. A phase model tracks one operation at a time and predicts
// the control outputs, the round-robin grant and the counters. Expected products
// go into per-port queues when a request is issued and are popped when the DUT
// responds. A second instance with CNT_W=2 shares the same stimulus so that
// counter wrap can be observed.

module tb_imuldiv_mul_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] req0_msg_a = '0, req0_msg_b = '0, req1_msg_a = '0, req1_msg_b = '0;
  logic        req0_val = 1'b0, req1_val = 1'b0;
  logic        req0_rdy, req1_rdy;
  logic [63:0] resp0_msg, resp1_msg;
  logic        resp0_val, resp1_val;
  logic        resp0_rdy = 1'b0, resp1_rdy = 1'b0;
  logic [31:0] mul_req_msg_a, mul_req_msg_b;
  logic        mul_req_val;
  logic        mul_req_rdy = 1'b0;
  logic [63:0] mul_resp_msg = '0;
  logic        mul_resp_val = 1'b0;
  logic        mul_resp_rdy;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  state_dbg;

  // outputs of the narrow-counter instance
  logic        d2_req0_rdy, d2_req1_rdy, d2_resp0_val, d2_resp1_val;
  logic        d2_mul_req_val, d2_mul_resp_rdy;
  logic [63:0] d2_resp0_msg, d2_resp1_msg;
  logic [31:0] d2_mul_req_msg_a, d2_mul_req_msg_b;
  logic [1:0]  d2_cnt0, d2_cnt1, d2_state_dbg;

  imuldiv_mul_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mul_req_msg_a(mul_req_msg_a), .mul_req_msg_b(mul_req_msg_b),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy),
    .mul_resp_msg(mul_resp_msg), .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy),
    .cnt0(cnt0), .cnt1(cnt1), .state_dbg(state_dbg)
  );

  imuldiv_mul_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(d2_req0_rdy),
    .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(d2_req1_rdy),
    .resp0_msg(d2_resp0_msg), .resp0_val(d2_resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg(d2_resp1_msg), .resp1_val(d2_resp1_val), .resp1_rdy(resp1_rdy),
    .mul_req_msg_a(d2_mul_req_msg_a), .mul_req_msg_b(d2_mul_req_msg_b),
    .mul_req_val(d2_mul_req_val), .mul_req_rdy(mul_req_rdy),
    .mul_resp_msg(mul_resp_msg), .mul_resp_val(mul_resp_val), .mul_resp_rdy(d2_mul_resp_rdy),
    .cnt0(d2_cnt0), .cnt1(d2_cnt1), .state_dbg(d2_state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: no expected event at %0t", name, $time);
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  function automatic logic [31:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h8000_0000;
    if (k == 1) return 32'hFFFF_FFFF;
    if (k == 2) return 32'd0;
    return $urandom;
  endfunction

  // ---------------- behavioural multiplier ----------------
  int mul_mode = 2;     // 0 random rdy, 1 rdy held low, 2 rdy whenever free
  int mul_lat  = 1;     // <0 random latency
  int rr_mode[2] = '{2, 2};  // response rdy: 0 random, 1 low, 2 high

  // Accepts one operation, answers after a latency, holds val until taken
  initial begin
    bit m_busy = 0;
    bit acc, fin, rst_s;
    int m_cnt = 0;
    int md, lat_s;
    logic [63:0] m_res = '0;
    logic [63:0] m_nxt = '0;
    forever begin
      @(negedge clk);
      rst_s = reset;
      acc   = mul_req_val && mul_req_rdy;
      fin   = mul_resp_val && mul_resp_rdy;
      md    = mul_mode;
      lat_s = mul_lat;
      if (acc) m_nxt = smul(mul_req_msg_a, mul_req_msg_b);
      @(posedge clk);
      #1;
      if (rst_s) begin
        m_busy = 0;
        mul_resp_val = 1'b0;
      end else begin
        if (fin) begin
          m_busy = 0;
          mul_resp_val = 1'b0;
        end
        if (acc) begin
          m_busy = 1;
          m_res  = m_nxt;
          m_cnt  = (lat_s < 0) ? $urandom_range(0, 4) : lat_s;
        end
        if (m_busy && !mul_resp_val) begin
          if (m_cnt == 0) mul_resp_val = 1'b1;
          else m_cnt--;
        end
      end
      mul_resp_msg = mul_resp_val ? m_res : {$urandom, $urandom};
      if (md == 1)      mul_req_rdy = 1'b0;
      else if (md == 2) mul_req_rdy = !m_busy;
      else              mul_req_rdy = !m_busy && ($urandom_range(0, 3) != 0);
    end
  end

  // Requester-side response readiness
  initial begin
    int m0, m1;
    forever begin
      @(negedge clk);
      m0 = rr_mode[0];
      m1 = rr_mode[1];
      @(posedge clk);
      #1;
      resp0_rdy = (m0 == 0) ? ($urandom_range(0, 2) != 0) : (m0 == 2);
      resp1_rdy = (m1 == 0) ? ($urandom_range(0, 2) != 0) : (m1 == 2);
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  initial begin
    int phase = 0;    // 0 free, 1 waiting on multiplier, 2 result offered
    int owner = 0;
    int last_g = 1;   // so that port 0 wins the first contention
    int cntm[2] = '{0, 0};
    logic [63:0] buf_m = '0;
    logic any;
    int g;
    logic [5:0] e;
    logic [31:0] ea, eb;
    @(posedge clk);
    forever begin
      @(negedge clk);
      any = (req0_val || req1_val) && !reset;
      g = (req0_val && req1_val) ? (1 - last_g) : (req1_val ? 1 : 0);
      case (phase)
        0: e = {any && g == 0 && mul_req_rdy, any && g == 1 && mul_req_rdy, any, 3'b000};
        1: e = 6'b000100;
        default: e = {4'b0000, owner == 0, owner == 1};
      endcase
      chk("ctrl{rdy0,rdy1,mreqv,mrespr,rv0,rv1}",
          64'({req0_rdy, req1_rdy, mul_req_val, mul_resp_rdy, resp0_val, resp1_val}), 64'(e));
      if (phase == 0) begin
        ea = any ? (g == 1 ? req1_msg_a : req0_msg_a) : 32'd0;
        eb = any ? (g == 1 ? req1_msg_b : req0_msg_b) : 32'd0;
        chk("mul_req_msg_a", 64'(mul_req_msg_a), 64'(ea));
        chk("mul_req_msg_b", 64'(mul_req_msg_b), 64'(eb));
      end
      if (phase == 2) begin
        chk("resp0_msg_hold", resp0_msg, buf_m);
        chk("resp1_msg_hold", resp1_msg, buf_m);
      end
      chk("cnt0", 64'(cnt0), 64'(cntm[0] % 65536));
      chk("cnt1", 64'(cnt1), 64'(cntm[1] % 65536));
      chk("cnt0_w2", 64'(d2_cnt0), 64'(cntm[0] % 4));
      chk("cnt1_w2", 64'(d2_cnt1), 64'(cntm[1] % 4));
      if (reset) begin
        phase = 0;
        last_g = 1;
        cntm = '{0, 0};
        exp_q0.delete();
        exp_q1.delete();
      end else begin
        if (resp0_val && resp0_rdy) begin
          if (exp_q0.size() == 0) fail_now("resp0_unexpected");
          else chk("resp0_data", resp0_msg, exp_q0.pop_front());
        end
        if (resp1_val && resp1_rdy) begin
          if (exp_q1.size() == 0) fail_now("resp1_unexpected");
          else chk("resp1_data", resp1_msg, exp_q1.pop_front());
        end
        case (phase)
          0: if (any && mul_req_rdy) begin
               owner = g;
               last_g = g;
               if (g == 1) exp_q1.push_back(smul(req1_msg_a, req1_msg_b));
               else        exp_q0.push_back(smul(req0_msg_a, req0_msg_b));
               phase = 1;
             end
          1: if (mul_resp_val) begin
               buf_m = mul_resp_msg;
               phase = 2;
             end
          default: if (owner == 1 ? resp1_rdy : resp0_rdy) begin
               cntm[owner]++;
               phase = 0;
             end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request and hold it until it is accepted (bounded)
  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bit done = 0;
    if (p == 0) begin req0_msg_a = a; req0_msg_b = b; req0_val = 1'b1; end
    else        begin req1_msg_a = a; req1_msg_b = b; req1_val = 1'b1; end
    while (!done) begin
      @(negedge clk);
      if (!reset && (p == 0 ? req0_rdy : req1_rdy)) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        fail_now(p == 0 ? "req0_accept_timeout" : "req1_accept_timeout");
        done = 1;
      end
    end
    if (p == 0) begin req0_val = 1'b0; req0_msg_a = $urandom; req0_msg_b = $urandom; end
    else        begin req1_val = 1'b0; req1_msg_a = $urandom; req1_msg_b = $urandom; end
  endtask

  // Wait for a response valid on port p; leaves time at the negedge where it is seen
  task automatic wait_resp(input int p, output bit seen);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (p == 0 ? resp0_val : resp1_val) seen = 1;
    end
    if (!seen) fail_now(p == 0 ? "resp0_timeout" : "resp1_timeout");
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic port_loop(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      cyc($urandom_range(0, 3));
      send(p, rand_op(), rand_op());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    cyc(3);
    reset = 1'b0;

    // single port-0 operation with a known product
    send(0, 32'd7, 32'hFFFF_FFFD);
    wait_resp(0, seen);
    if (seen) chk("single_op_product", resp0_msg, 64'hFFFF_FFFF_FFFF_FFEB);
    cyc(3);
    chk("single_op_cnt0", 64'(cnt0), 64'd1);

    // contention from reset, two rounds
    reset_dut();
    repeat (2) begin
      fork
        send(0, rand_op(), rand_op());
        send(1, rand_op(), rand_op());
      join
      cyc(4);
    end

    // owner stalls its response for several cycles
    rr_mode[0] = 1;
    cyc(1);
    send(0, rand_op(), rand_op());
    wait_resp(0, seen);
    cyc(6);
    rr_mode[0] = 2;
    cyc(4);

    // multiplier not ready while port 1 waits, then contention to exercise the pointer
    mul_mode = 1;
    cyc(2);
    fork
      send(1, rand_op(), rand_op());
      begin cyc(3); mul_mode = 2; end
    join
    cyc(4);
    fork
      send(0, rand_op(), rand_op());
      send(1, rand_op(), rand_op());
    join
    cyc(4);

    // reset while the multiplier is busy, then a normal operation
    mul_lat = 8;
    send(0, rand_op(), rand_op());
    cyc(1);
    reset_dut();
    mul_lat = 1;
    cyc(12);
    send(1, 32'hFFFF_FFF0, 32'd5);
    wait_resp(1, seen);
    if (seen) chk("after_reset_product", resp1_msg, 64'hFFFF_FFFF_FFFF_FFB0);
    cyc(3);

    // randomized traffic on both ports
    mul_mode = 0;
    mul_lat = -1;
    rr_mode = '{0, 0};
    fork
      port_loop(0, 40);
      port_loop(1, 40);
    join
    rr_mode = '{2, 2};
    cyc(30);
    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
